instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Consumer side of the 12-bit program counter: issues reads to program memory at pc_q,
//  drives the PC's hold/increment/load controls, buffers returned words with their address
//  and hands them to the decoder over a valid/ready handshake. Branch/jump redirects from
//  execute flush the buffer and reload the PC. Sits between PC register, imem and decoder.
// PARAMETERS
//  PC_W       12  program counter / imem address width
//  INSTR_W    16  instruction word width
//  FIFO_DEPTH 2   fetch buffer entries (>=2 for one instr/cycle throughput)
// PORTS
//  clk             in  1        single clock, all logic on posedge
//  rst_n           in  1        asynchronous active-low reset
//  fetch_en        in  1        1 = fetch running, 0 = halted (no new issues)
//  redirect_valid  in  1        execute requests PC change this cycle
//  redirect_addr   in  PC_W     redirect target
//  pc_q            in  PC_W     current PC value
//  pc_hold         out 1        PC hold control
//  pc_increment    out 1        PC increment control
//  pc_load         out 1        PC load control
//  pc_d            out PC_W     PC load value
//  imem_req        out 1        read strobe; sync memory returns data exactly 1 cycle later
//  imem_addr       out PC_W     read address
//  imem_rdata      in  INSTR_W  read data, valid cycle after imem_req
//  instr_valid     out 1        buffer head valid
//  instr_ready     in  1        decoder accepts head
//  instr_data      out INSTR_W  head instruction
//  instr_pc        out PC_W     head instruction address
// BEHAVIOUR
//  Reset: state IDLE, buffer empty, in-flight flag 0; pc_hold=1, pc_increment=0, pc_load=0,
//   pc_d=0, imem_req=0, imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0.
//  PC control: PC gives increment priority over load, so never assert both; pc_hold=1
//   whenever neither issue nor redirect occurs this cycle.
//  States: IDLE -(fetch_en)-> RUN; RUN -(!fetch_en)-> IDLE; any -(redirect_valid)-> FLUSH;
//   FLUSH -> RUN if fetch_en else IDLE. FLUSH lasts exactly 1 cycle.
//  Issue (RUN only, no redirect): when count + inflight - pop < FIFO_DEPTH, where
//   pop = instr_valid & instr_ready: imem_req=1, imem_addr=pc_q, pc_increment=1, pc_hold=0;
//   the issued address is captured as response tag.
//  Return: cycle after issue, if not squashed, push {tag, imem_rdata}; instr_valid rises
//   the following cycle => issue-to-instr_valid latency 2 cycles; 1 instr/cycle sustained.
//  Redirect (any state): pc_load=1, pc_d=redirect_addr, pc_hold=0, pc_increment=0,
//   no issue; buffer flushed (instr_valid=0 next cycle); response returning next cycle
//   is squashed. A pop coinciding with redirect completes normally.
//  Halt: fetch_en=0 stops issue; in-flight response still pushed; buffer drains normally.
//  Wrap: pc_q=0xFFF issues 0xFFF, PC wraps to 0x000; instr_pc carries 0xFFF then 0x000.
//  Full buffer, no pop: no issue, pc_hold=1; head stable while instr_valid & !instr_ready.
//  Reset mid-operation: buffer, in-flight and state cleared immediately; squashes all.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetched[15:0] (pops) and perf_redirects[15:0]
//   (redirect cycles), saturating at 0xFFFF, reset to 0. Undefined: ports and counters absent,
//   behaviour otherwise identical.
// STRUCTURE
//  cpu_pkg: PC_W, INSTR_W constants, fetch state enum (IDLE/RUN/FLUSH), fetch entry struct
//   {pc, instr}. Sub-module fetch_fifo: FIFO_DEPTH x entry, push/pop/flush, count out,
//   registered head; controller FSM and issue/credit logic live in instr_fetch_unit.
// TESTING
//  1 Reset, fetch_en=1, pc starts 0x000, ready=1 -> imem_addr 0x000,0x001,0x002 on
//    consecutive cycles; instr_valid first 2 cycles after first issue; instr_pc 0,1,2.
//  2 ready=0 for 5 cycles after 2 words buffered -> issue stops, pc_hold=1, head stays
//    {0x000, mem[0]}; ready=1 -> pops resume in order with no loss or duplication.
//  3 redirect_valid with addr 0x2A0 while buffer full and one in flight -> pc_load=1,
//    pc_d=0x2A0; next cycle instr_valid=0; first delivered instr_pc=0x2A0.
//  4 PC at 0xFFE, run -> instr_pc sequence 0xFFE, 0xFFF, 0x000, 0x001.
//  5 fetch_en dropped one cycle after an issue -> in-flight word still delivered, no
//    further imem_req; redirect to 0x010 while halted loads PC, stays IDLE.
//  6 rst_n asserted mid-stream -> all outputs at reset values asynchronously; with
//    FETCH_PERF_EN, perf counters match pop/redirect counts and return to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the fetch path: address/instruction widths, fetch FSM states
// and the buffered fetch entry.
package cpu_pkg;
  localparam int PC_W    = 12;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: program memory read port plus the decoder valid/ready port.
// master = fetch unit, slave = memory/decoder side.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small fetch buffer of {pc, instr} entries with push/pop/flush and an occupancy count.
// The head is read straight from the storage registers.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  // a push into a full buffer is only legal when the head leaves in the same cycle
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= wdata;
        wr_ptr        <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head = store[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch controller: drives PC hold/increment/load, issues imem reads and
// buffers returned words for the decoder. FETCH_PERF_EN adds pop/redirect counters.
//
// state | meaning
// IDLE  | halted, no issue
// RUN   | issuing one read per cycle while buffer credit allows
// FLUSH | one cycle after a redirect, buffer empty, no issue
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_addr,
  input  logic [PC_W-1:0]     pc_q,
  output logic                pc_hold,
  output logic                pc_increment,
  output logic                pc_load,
  output logic [PC_W-1:0]     pc_d,
  instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         perf_fetched,
  output logic [15:0]         perf_redirects
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic             inflight;
  logic [PC_W-1:0]  tag;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             credit_ok;
  logic             issue;
  logic             pop;
  logic             push;
  fetch_entry_t     wentry;
  fetch_entry_t     head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (issue) tag <= pc_q;
    end
  end

  assign pop       = bus.instr_valid & bus.instr_ready;
  // the redirect cycle's returning word belongs to the abandoned path
  assign push      = inflight & ~redirect_valid;
  assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    state_nxt    = state;
    issue        = 1'b0;
    pc_hold      = 1'b1;
    pc_increment = 1'b0;
    pc_load      = 1'b0;
    pc_d         = '0;
    case (state)
      IDLE:    if (fetch_en) state_nxt = RUN;
      RUN:     if (!fetch_en) state_nxt = IDLE;
      FLUSH:   state_nxt = fetch_en ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      state_nxt = FLUSH;
      pc_load   = 1'b1;
      pc_d      = redirect_addr;
      pc_hold   = 1'b0;
    end else if (state == RUN && fetch_en && credit_ok) begin
      issue        = 1'b1;
      pc_increment = 1'b1;
      pc_hold      = 1'b0;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = issue ? pc_q : '0;
  assign wentry        = '{pc: tag, instr: bus.imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .head  (head),
    .count (count)
  );

  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = bus.instr_valid ? head.instr : '0;
  assign bus.instr_pc    = bus.instr_valid ? head.pc : '0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (pop && !(&perf_fetched)) perf_fetched <= perf_fetched + 16'd1;
      if (redirect_valid && !(&perf_redirects)) perf_redirects <= perf_redirects + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: models the PC register and a synchronous program memory,
// and checks the delivered instruction stream against the expected program order.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            fetch_en = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_addr = '0;
  logic [PC_W-1:0] pc_q;
  logic            pc_hold;
  logic            pc_increment;
  logic            pc_load;
  logic [PC_W-1:0] pc_d;
`ifdef FETCH_PERF_EN
  logic [15:0]     perf_fetched;
  logic [15:0]     perf_redirects;
`endif

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .pc_q           (pc_q),
    .pc_hold        (pc_hold),
    .pc_increment   (pc_increment),
    .pc_load        (pc_load),
    .pc_d           (pc_d),
    .bus            (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  // program memory and PC register models
  logic [INSTR_W-1:0] mem [4096];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else if (pc_increment) pc_q <= pc_q + 1'b1;
    else if (pc_load) pc_q <= pc_d;
  end

  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req ? mem[bus.imem_addr] : INSTR_W'($urandom);
  end

  int              n_checks = 0;
  int              n_fail = 0;
  logic [PC_W-1:0] exp_pc = '0;
  int              outstanding = 0;
  int              pops = 0;
  int              redirs = 0;
  logic [PC_W-1:0] popped [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // per-cycle checks against the program-order model; called 1ns after the negedge
  task automatic sample();
    #1;
    check("pc_excl", 32'(pc_increment & pc_load), 0);
    check("pc_hold", 32'(pc_hold), 32'(!(pc_increment | pc_load)));
    if (bus.imem_req) begin
      check("issue_addr", 32'(bus.imem_addr), 32'(pc_q));
      check("issue_inc", 32'(pc_increment), 1);
      outstanding++;
    end
    if (!fetch_en) check("halt_noreq", 32'(bus.imem_req), 0);
    if (redirect_valid) begin
      check("redir_load", 32'(pc_load), 1);
      check("redir_pcd", 32'(pc_d), 32'(redirect_addr));
      check("redir_noreq", 32'(bus.imem_req), 0);
    end
    if (bus.instr_valid && bus.instr_ready) begin
      check("pop_pc", 32'(bus.instr_pc), 32'(exp_pc));
      check("pop_data", 32'(bus.instr_data), 32'(mem[exp_pc]));
      popped.push_back(bus.instr_pc);
      exp_pc++;
      outstanding--;
      pops++;
    end
    if (redirect_valid) begin
      exp_pc = redirect_addr;
      outstanding = 0;
      redirs++;
    end
    check("credit", 32'(outstanding <= DEPTH), 1);
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    next();
  endtask

  task automatic reset_checks();
    check("rst_hold", 32'(pc_hold), 1);
    check("rst_inc", 32'(pc_increment), 0);
    check("rst_load", 32'(pc_load), 0);
    check("rst_pcd", 32'(pc_d), 0);
    check("rst_req", 32'(bus.imem_req), 0);
    check("rst_addr", 32'(bus.imem_addr), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_data", 32'(bus.instr_data), 0);
    check("rst_ipc", 32'(bus.instr_pc), 0);
`ifdef FETCH_PERF_EN
    check("rst_perf_f", 32'(perf_fetched), 0);
    check("rst_perf_r", 32'(perf_redirects), 0);
`endif
  endtask

  // called at a negedge; asserts reset mid-cycle, returns at a negedge right after release
  task automatic do_reset(input bit chk_perf);
    redirect_valid = 1'b0;
`ifdef FETCH_PERF_EN
    if (chk_perf) begin
      check("perf_fetched", 32'(perf_fetched), 32'(pops));
      check("perf_redirects", 32'(perf_redirects), 32'(redirs));
    end
`endif
    #3 rst_n = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
    outstanding = 0;
    pops = 0;
    redirs = 0;
    popped.delete();
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int k = 0; k < budget && popped.size() < n; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    for (int i = 0; i < 4096; i++) mem[i] = INSTR_W'($urandom);
    bus.instr_ready = 1'b0;

    // reset, then straight-line fetch from 0x000
    fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) begin
      sample();
      check("t1_req", 32'(bus.imem_req), 32'(k >= 1));
      if (k >= 1) check("t1_addr", 32'(bus.imem_addr), 32'(k - 1));
      check("t1_valid", 32'(bus.instr_valid), 32'(k >= 3));
      if (k >= 3) check("t1_ipc", 32'(bus.instr_pc), 32'(k - 3));
      next();
    end

    // decoder stalls from the start: two words buffered, issue stops, head stable
    bus.instr_ready = 1'b0;
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      sample();
      if (k >= 3) begin
        check("t2_noreq", 32'(bus.imem_req), 0);
        check("t2_hold", 32'(pc_hold), 1);
        check("t2_valid", 32'(bus.instr_valid), 1);
        check("t2_head_pc", 32'(bus.instr_pc), 0);
        check("t2_head_data", 32'(bus.instr_data), 32'(mem[0]));
      end
      next();
    end
    bus.instr_ready = 1'b1;
    repeat (20) step();
    check("t2_resume_pops", 32'(pops >= 18), 1);

    // redirect while the buffer credit is exhausted and a word is in flight
    redirect_valid = 1'b1;
    redirect_addr = 12'h2A0;
    sample();
    check("t3_load", 32'(pc_load), 1);
    check("t3_pcd", 32'(pc_d), 32'h2A0);
    check("t3_inc", 32'(pc_increment), 0);
    next();
    redirect_valid = 1'b0;
    sample();
    check("t3_flushed", 32'(bus.instr_valid), 0);
    next();
    popped.delete();
    wait_pops(1, 10);
    check("t3_first_pc", 32'(popped.size() > 0 ? popped[0] : 12'hFFF), 32'h2A0);

    // address wrap at the top of the PC range
    redirect_valid = 1'b1;
    redirect_addr = 12'hFFE;
    step();
    redirect_valid = 1'b0;
    popped.delete();
    wait_pops(4, 15);
    check("t4_count", 32'(popped.size() >= 4), 1);
    for (int k = 0; k < 4 && k < popped.size(); k++)
      check("t4_wrap_pc", 32'(popped[k]), 32'((12'hFFE + k) % 4096));

    // halt one cycle after an issue: in-flight word drains, nothing new issued
    repeat (3) step();
    p0 = pops;
    fetch_en = 1'b0;
    repeat (6) step();
    check("t5_drain_pops", 32'(pops - p0), 2);
    sample();
    check("t5_empty", 32'(bus.instr_valid), 0);
    check("t5_drained", 32'(exp_pc), 32'(pc_q));
    next();
    redirect_valid = 1'b1;
    redirect_addr = 12'h010;
    step();
    redirect_valid = 1'b0;
    repeat (4) step();
    check("t5_pc_loaded", 32'(pc_q), 32'h010);
    fetch_en = 1'b1;
    popped.delete();
    wait_pops(1, 10);
    check("t5_resume_pc", 32'(popped.size() > 0 ? popped[0] : 12'hFFF), 32'h010);

    // randomized traffic against the program-order model
    p0 = pops;
    for (int k = 0; k < 400; k++) begin
      fetch_en = ($urandom_range(0, 9) != 0);
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr = PC_W'($urandom);
      step();
    end
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (5) step();
    check("rand_progress", 32'(pops - p0 > 50), 1);

    // reset mid-stream, then restart from 0x000
    do_reset(1'b1);
    popped.delete();
    wait_pops(3, 10);
    check("t6_restart", 32'(popped.size() >= 3 ? popped[2] : 12'hFFF), 32'h002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
